// File: rtl/board_pkg.sv
// Shared board definitions: geometry, command encodings, piece fields and
// the sequencer state type.
package board_pkg;

    localparam int NUM_SQ  = 64;
    localparam int SQ_W    = 6;
    localparam int PIECE_W = 10;

    localparam int OCC_BIT   = 9;
    localparam int COLOR_BIT = 8;

    localparam logic [PIECE_W-1:0] EMPTY_PIECE = '0;

    typedef enum logic [1:0] {
        OP_MOVE      = 2'd0,
        OP_PLACE     = 2'd1,
        OP_CLEAR_ALL = 2'd2,
        OP_RSVD      = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_SRC,
        ST_RD_DST,
        ST_CHECK,
        ST_WR_DST,
        ST_CLR_SRC,
        ST_CLR_ALL,
        ST_RESP
    } state_e;

    // A move is legal when the source holds a piece, the squares differ and
    // the destination is either empty or holds an opposing piece.
    function automatic logic move_legal(
        input logic [SQ_W-1:0]    src,
        input logic [SQ_W-1:0]    dst,
        input logic [PIECE_W-1:0] src_piece,
        input logic [PIECE_W-1:0] dst_piece
    );
        logic same_colour_block;
        same_colour_block = dst_piece[OCC_BIT] &&
                            (dst_piece[COLOR_BIT] == src_piece[COLOR_BIT]);
        return src_piece[OCC_BIT] && (src != dst) && !same_colour_block;
    endfunction

endpackage

// File: rtl/sq_decoder.sv
// Square index to one-hot enable decoder, gated by a single enable.
module sq_decoder #(
    parameter int N = 64,
    parameter int W = 6
) (
    input  logic [W-1:0] idx,
    input  logic         en,
    output logic [N-1:0] onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dec
            assign onehot[gi] = en && (idx == W'(gi));
        end
    endgenerate

endmodule

// File: rtl/move_sequencer.sv
// Command sequencer for the board piece registers: runs MOVE (read, validate,
// write, clear), PLACE and CLEAR_ALL, and is the only writer of the board.
module move_sequencer
    import board_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [SQ_W-1:0]     cmd_src,
    input  logic [SQ_W-1:0]     cmd_dst,
    input  logic [PIECE_W-1:0]  cmd_piece,
    output logic [SQ_W-1:0]     rd_addr,
    input  logic [PIECE_W-1:0]  rd_data,
    output logic [NUM_SQ-1:0]   sq_enable,
    output logic [PIECE_W-1:0]  sq_wdata,
    output logic                done,
    output logic                err,
    output logic                cap_valid,
    output logic [PIECE_W-1:0]  cap_piece
);

    state_e               state_reg, state_next;
    op_e                  op_reg;
    logic [SQ_W-1:0]      src_reg, dst_reg;
    logic [PIECE_W-1:0]   piece_reg;
    logic [PIECE_W-1:0]   src_piece_reg, dst_piece_reg;
    logic [PIECE_W-1:0]   cap_piece_reg;
    logic                 err_reg, cap_flag_reg;

    logic                 accept;
    logic                 move_ok;
    logic [SQ_W-1:0]      dec_idx;
    logic                 dec_en;
    logic [NUM_SQ-1:0]    dec_onehot;

    assign accept  = cmd_valid && (state_reg == ST_IDLE);
    assign move_ok = move_legal(src_reg, dst_reg, src_piece_reg, dst_piece_reg);

    // Single-square writes: destination in WR_DST, source in CLR_SRC.
    assign dec_idx = (state_reg == ST_WR_DST) ? dst_reg : src_reg;
    assign dec_en  = (state_reg == ST_WR_DST) || (state_reg == ST_CLR_SRC);

    sq_decoder #(
        .N (NUM_SQ),
        .W (SQ_W)
    ) u_dec (
        .idx    (dec_idx),
        .en     (dec_en),
        .onehot (dec_onehot)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Command latch, board read capture and response bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_reg        <= OP_MOVE;
            src_reg       <= '0;
            dst_reg       <= '0;
            piece_reg     <= EMPTY_PIECE;
            src_piece_reg <= EMPTY_PIECE;
            dst_piece_reg <= EMPTY_PIECE;
            cap_piece_reg <= EMPTY_PIECE;
            err_reg       <= 1'b0;
            cap_flag_reg  <= 1'b0;
        end else begin
            if (accept) begin
                op_reg       <= op_e'(cmd_op);
                src_reg      <= cmd_src;
                dst_reg      <= cmd_dst;
                piece_reg    <= cmd_piece;
                err_reg      <= (op_e'(cmd_op) == OP_RSVD);
                cap_flag_reg <= 1'b0;
            end
            if (state_reg == ST_RD_SRC) begin
                src_piece_reg <= rd_data;
            end
            if (state_reg == ST_RD_DST) begin
                dst_piece_reg <= rd_data;
            end
            if (state_reg == ST_CHECK) begin
                err_reg <= !move_ok;
            end
            // Only a completed MOVE updates the capture report; everything
            // else leaves cap_piece at its previous value.
            if (state_reg == ST_CLR_SRC) begin
                cap_flag_reg  <= dst_piece_reg[OCC_BIT];
                cap_piece_reg <= dst_piece_reg;
            end
        end
    end

    // Next-state sequencing for each command type.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    case (op_e'(cmd_op))
                        OP_MOVE:      state_next = ST_RD_SRC;
                        OP_PLACE:     state_next = ST_WR_DST;
                        OP_CLEAR_ALL: state_next = ST_CLR_ALL;
                        default:      state_next = ST_RESP;
                    endcase
                end
            end
            ST_RD_SRC:  state_next = ST_RD_DST;
            ST_RD_DST:  state_next = ST_CHECK;
            ST_CHECK:   state_next = move_ok ? ST_WR_DST : ST_RESP;
            ST_WR_DST:  state_next = (op_reg == OP_MOVE) ? ST_CLR_SRC : ST_RESP;
            ST_CLR_SRC: state_next = ST_RESP;
            ST_CLR_ALL: state_next = ST_RESP;
            ST_RESP:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from the current state; all idle at zero.
    always_comb begin
        cmd_ready = 1'b0;
        rd_addr   = '0;
        sq_enable = '0;
        sq_wdata  = EMPTY_PIECE;
        done      = 1'b0;
        err       = 1'b0;
        cap_valid = 1'b0;
        case (state_reg)
            ST_IDLE:   cmd_ready = 1'b1;
            ST_RD_SRC: rd_addr = src_reg;
            ST_RD_DST: rd_addr = dst_reg;
            ST_WR_DST: begin
                sq_enable = dec_onehot;
                sq_wdata  = (op_reg == OP_MOVE) ? src_piece_reg : piece_reg;
            end
            ST_CLR_SRC: sq_enable = dec_onehot;
            ST_CLR_ALL: sq_enable = '1;
            ST_RESP: begin
                done      = 1'b1;
                err       = err_reg;
                cap_valid = cap_flag_reg;
            end
            default: ;
        endcase
    end

    assign cap_piece = cap_piece_reg;

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Sequences all writes into the board's array of per-square piece registers (NUM_SQ squares, each PIECE_W bits, each with its own write enable).
- Accepts one command at a time over a valid/ready handshake: MOVE, PLACE or CLEAR_ALL.
- For a MOVE it reads the source and destination squares through the board read mux, then validates the move. If valid, it writes the destination, clears the source and reports any captured piece.
- Sits between game-control logic and the board storage; it is the only driver of the square enables and of the shared write-data bus.

Parameters:
- NUM_SQ, 64, number of squares / piece registers.
- SQ_W, 6, square index width (clog2 of NUM_SQ).
- PIECE_W, 10, piece word width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  2  0=MOVE, 1=PLACE, 2=CLEAR_ALL, 3=reserved.
- cmd_src  input  SQ_W  source square (MOVE only).
- cmd_dst  input  SQ_W  destination square (MOVE, PLACE).
- cmd_piece  input  PIECE_W  piece to write (PLACE only).
- rd_addr  output  SQ_W  square select for the external combinational board read mux.
- rd_data  input  PIECE_W  contents of square rd_addr, same cycle.
- sq_enable  output  NUM_SQ  per-square write enables.
- sq_wdata  output  PIECE_W  write data shared by all squares.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; 1 = command rejected, no write performed.
- cap_valid  output  1  valid with done; MOVE captured a piece.
- cap_piece  output  PIECE_W  captured piece, valid with cap_valid.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Piece format:
  - bit 9 = occupied.
  - bit 8 = colour.
  - bits 7:0 = type/id.
  - The all-zero word is the empty square.
- Reset:
  - State returns to IDLE.
  - sq_enable=0, sq_wdata=0, rd_addr=0.
  - done=0, err=0, cap_valid=0, cap_piece=0.
  - cmd_ready=1 after reset release.
- Handshake:
  - cmd_ready=1 only in IDLE.
  - A command is accepted on a rising edge with cmd_valid && cmd_ready; op, src, dst and piece are latched on that edge.
  - cmd_valid while busy is ignored, not queued.
- States: IDLE, RD_SRC, RD_DST, CHECK, WR_DST, CLR_SRC, CLR_ALL, RESP. Every write is a single-cycle enable; at most one square is enabled per cycle except in CLR_ALL.
- MOVE, counted in cycles after acceptance:
  - c1 RD_SRC: rd_addr=src; src_piece latched at the end of the cycle.
  - c2 RD_DST: rd_addr=dst; dst_piece latched at the end of the cycle.
  - c3 CHECK: reject if src_piece[9]==0, src==dst, or (dst_piece[9] && dst_piece[8]==src_piece[8]). Reject goes to RESP with err=1; otherwise go to WR_DST.
  - c4 WR_DST: sq_enable = one-hot(dst), sq_wdata = src_piece.
  - c5 CLR_SRC: sq_enable = one-hot(src), sq_wdata = 0.
  - c6 RESP: done=1, err=0, cap_valid=dst_piece[9], cap_piece=dst_piece.
  - c7: back in IDLE, cmd_ready=1.
- Rejected MOVE: RESP at c4; no sq_enable asserted at any point.
- PLACE:
  - c1 WR_DST: one-hot(dst), sq_wdata = cmd_piece.
  - c2 RESP: done=1, err=0, cap_valid=0.
  - PLACE overwrites unconditionally; writing 0 empties a square.
- CLEAR_ALL:
  - c1 CLR_ALL: sq_enable = all ones, sq_wdata = 0.
  - c2 RESP: done=1.
- Reserved op: straight to RESP at c1 with err=1.
- Outputs outside RESP: done=0, err=0, cap_valid=0. cap_piece holds its last value.
- Outputs outside write states: sq_enable=0, sq_wdata=0.
- Reset mid-operation aborts immediately. A cycle already written is not undone, but the board registers share rst, so the board is empty after reset anyway.
- Next command: accepted no earlier than the cycle after RESP; back-to-back throughput is one MOVE per 7 cycles.

Decomposition:
- Shared package (board_pkg): NUM_SQ, SQ_W, PIECE_W, op encodings, piece field indices (OCC_BIT=9, COLOR_BIT=8), EMPTY_PIECE=0.
- Sub-module sq_decoder: SQ_W index plus enable in, NUM_SQ one-hot out. Reused by the board read/write glue.

Test Plan:
- Reset, then PLACE dst=12 piece=0x301 → c1 sq_enable=1<<12, sq_wdata=0x301; c2 done=1 err=0; cmd_ready low for exactly 2 cycles.
- Board square 12=0x301 and 28 empty; MOVE 12→28 → c4 enable bit 28 wdata 0x301; c5 enable bit 12 wdata 0; c6 done=1 err=0 cap_valid=0.
- Square 28=0x301 and 36=0x205; MOVE 28→36 → capture: c6 cap_valid=1, cap_piece=0x205; square 36 then holds 0x301 and square 28 holds 0.
- Reject cases → done=1 err=1 at c4, sq_enable never nonzero:
  - MOVE from empty square 5.
  - MOVE 7→7.
  - MOVE 0x301→0x302 (same colour).
- CLEAR_ALL → c1 sq_enable=all ones, sq_wdata=0; c2 done; op=3 → c1 done err=1.
- cmd_valid held high during a MOVE with a second command → second command accepted only at c7. Separately, assert rst at c4 of a MOVE → all outputs 0 asynchronously and IDLE with cmd_ready=1 after release.
